// File: rtl/lsu_pkg.sv
// LSU shared types: FSM state encoding and request size codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        WAIT_R,
        DONE
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replication, load extraction
// and extension, plus misalignment / illegal-size detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OB = XLEN / 8,
    localparam int OW = $clog2(XLEN / 8)
) (
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    input  logic [OW-1:0]   off_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [OB-1:0]   wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o,
    output logic            illegal_o
);

    logic [7:0]      mask8;
    logic [XLEN-1:0] sh;
    logic            sgn;
    int              lim;

    always_comb begin
        mask8      = 8'h01;
        wdata_o    = {OB{wdata_i[7:0]}};
        lim        = 8;
        misalign_o = 1'b0;
        case (size_i)
            SZ_H: begin
                mask8      = 8'h03;
                wdata_o    = {(OB/2){wdata_i[15:0]}};
                lim        = 16;
                misalign_o = off_i[0];
            end
            SZ_W: begin
                mask8      = 8'h0F;
                wdata_o    = {(OB/4){wdata_i[31:0]}};
                lim        = 32;
                misalign_o = |off_i[1:0];
            end
            SZ_D: begin
                mask8      = 8'hFF;
                wdata_o    = wdata_i;
                lim        = XLEN;
                misalign_o = |off_i;
            end
            default: ;
        endcase
        wstrb_o = mask8[OB-1:0] << off_i;
    end

    assign illegal_o = (size_i == SZ_D) && (XLEN != 64);
    assign sh        = rdata_i >> {off_i, 3'b000};

    // Bits above the access width take the sign bit (or zero).
    always_comb begin
        rdata_o = sh;
        sgn     = ~uns_i & sh[lim-1];
        for (int i = 0; i < XLEN; i++) begin
            if (i >= lim) rdata_o[i] = sgn;
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, single-beat bus with
// optional delayed read data and a bounded wait.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int OB = XLEN / 8;
    localparam int OW = $clog2(OB);
    localparam int CW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic            st_q, uns_q, err_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      a_size;
    logic [OW-1:0]   a_off;
    logic [OB-1:0]   strb;
    logic [XLEN-1:0] rep, ext;
    logic            mis, ill, act, cpl, tmo;

    // In IDLE the aligner judges the incoming request; afterwards the latched one.
    assign a_size = (state_q == IDLE) ? req_size : size_q;
    assign a_off  = (state_q == IDLE) ? req_addr[OW-1:0] : addr_q[OW-1:0];

    lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (a_size),
        .uns_i      (uns_q),
        .off_i      (a_off),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .wstrb_o    (strb),
        .wdata_o    (rep),
        .rdata_o    (ext),
        .misalign_o (mis),
        .illegal_o  (ill)
    );

    assign act = (state_q == BUS) || (state_q == WAIT_R);
    assign tmo = cnt_q == CW'(TIMEOUT - 1);
    assign cpl = ((state_q == BUS) && mem_ready && (st_q || mem_rvalid))
              || ((state_q == WAIT_R) && mem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) state_d = (mis || ill) ? DONE : BUS;
            end
            BUS: begin
                if (cpl || tmo)     state_d = DONE;
                else if (mem_ready) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (cpl || tmo) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (req_valid && req_ready) begin
                st_q    <= req_is_store;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= mis | ill;
                rdata_q <= '0;
                cnt_q   <= '0;
            end
            if (act) begin
                cnt_q <= cnt_q + 1'b1;
                if (cpl && !st_q)   rdata_q <= ext;
                else if (tmo && !cpl) err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        mem_valid  = state_q == BUS;
        mem_we     = mem_valid & st_q;
        mem_addr   = '0;
        mem_wstrb  = '0;
        mem_wdata  = '0;
        if (mem_valid) begin
            mem_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
            if (st_q) begin
                mem_wstrb = strb;
                mem_wdata = rep;
            end
        end
        resp_valid = state_q == DONE;
        resp_err   = resp_valid & err_q;
        resp_rdata = resp_valid ? rdata_q : '0;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
  XLEN  32  data/address width; legal values 32 or 64.
  TIMEOUT  16  max cycles in BUS+WAIT_R before error; must be >= 2.
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  reset, synchronous, active-high.
  req_valid  in  1  core request present.
  req_ready  out  1  LSU idle; request accepted when req_valid & req_ready.
  req_is_store  in  1  1 = store, 0 = load.
  req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
  req_unsigned  in  1  load zero-extend; ignored for stores.
  req_addr  in  XLEN  byte address.
  req_wdata  in  XLEN  store data in low bits.
  resp_valid  out  1  one-cycle completion pulse.
  resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
  resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid.
  mem_valid  out  1  bus request.
  mem_ready  in  1  bus accepts request.
  mem_we  out  1  bus write.
  mem_addr  out  XLEN  XLEN/8-aligned address (low offset bits forced 0).
  mem_wstrb  out  XLEN/8  byte-lane enables; all 0 for loads.
  mem_wdata  out  XLEN  lane-replicated store data.
  mem_rvalid  in  1  load data returned.
  mem_rdata  in  XLEN  full bus word.

Function
REQ-003 SHALL implement FSM states IDLE, BUS, WAIT_R, DONE; req_ready=1 only in IDLE.
REQ-004 IDLE, accept: latch all req_* fields; misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0) or illegal size -> DONE with err=1, no bus access; else -> BUS.
REQ-005 BUS: mem_valid=1 with mem_addr/we/wstrb/wdata held stable until mem_ready; on mem_ready, store -> DONE, load -> WAIT_R.
REQ-006 Load with mem_rvalid asserted in the same cycle as mem_ready in BUS SHALL capture mem_rdata and go directly to DONE.
REQ-007 WAIT_R: on mem_rvalid capture data -> DONE; mem_rvalid outside BUS/WAIT_R SHALL be ignored.
REQ-008 Timeout counter cleared on entry to BUS, increments every cycle in BUS/WAIT_R; on the TIMEOUT-th such cycle without completion -> DONE with err=1, rdata=0; completion in that same cycle wins (err=0).
REQ-009 DONE: resp_valid=1 exactly one cycle, then IDLE; new request acceptable the cycle after DONE.
REQ-010 Latency: aligned store, mem_ready=1 immediately: accept cycle N, BUS N+1, resp_valid N+2; misaligned: resp_valid N+1.
REQ-011 Store lanes: off=addr[log2(XLEN/8)-1:0]; wstrb = size-mask << off; wdata = byte/half/word replicated across bus.
REQ-012 Load data: mem_rdata >> 8*off, truncated to size, sign-extended unless req_unsigned; double load unmodified.

Reset
REQ-013 rst high at clock edge: state IDLE, counter 0, req_ready=1, all other outputs 0 from the next cycle.
REQ-014 rst mid-transaction SHALL abandon it with no resp_valid; mem_valid low the cycle after reset.

Structure
REQ-015 Package lsu_pkg SHALL hold the state enum and req_size encodings (SZ_B, SZ_H, SZ_W, SZ_D).
REQ-016 Combinational sub-module lsu_align SHALL compute wstrb, wdata replication, load extraction/extension and misalign flag.

Verification
REQ-017 Store byte 0xAB to 0x1003, mem_ready=1 -> mem_addr=0x1000, wstrb=1000, wdata=0xABABABAB, resp_valid 2 cycles after accept, err=0.
REQ-018 Signed load half at 0x2002, mem_rdata=0x80010000, rvalid 3 cycles after grant -> resp_rdata=0xFFFF8001; same unsigned -> 0x00008001.
REQ-019 Load word at 0x3001 -> resp_valid next cycle, err=1, mem_valid never asserted.
REQ-020 TIMEOUT=4, mem_ready held 0 -> err=1 on 4th BUS cycle; variant with mem_ready on 4th cycle -> no error.
REQ-021 rst asserted in WAIT_R -> no resp_valid, req_ready=1 next cycle; XLEN=64 double load at 0x8 returns mem_rdata unchanged.
